// File: rtl/neo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neo_pkg
// Brief    : Shared types and default timing for the NeoPixel encoder.
// Revision : 1.0 - initial release
// ============================================================================
package neo_pkg;

    // Defaults assume a 50 MHz clock.
    localparam int c_t0h_cycles   = 18;
    localparam int c_t1h_cycles   = 35;
    localparam int c_bit_cycles   = 63;
    localparam int c_latch_cycles = 2500;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } neo_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } neo_grb_t;

endpackage
`default_nettype wire

// File: rtl/neo_pixel_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : neo_pixel_encoder_if
// Brief    : Pixel word valid/ready handshake between sequencer and encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface neo_pixel_encoder_if;
    import neo_pkg::*;

    neo_grb_t pix_grb;
    logic     pix_last;
    logic     pix_valid;
    logic     pix_ready;

    modport master (
        output pix_grb,
        output pix_last,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_grb,
        input  pix_last,
        input  pix_valid,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/neo_channel_scale.sv
`default_nettype none
// ============================================================================
// Module   : neo_channel_scale
// Brief    : Scales one colour channel by (brightness+1)/256; built only when
//            NEO_BRIGHTNESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef NEO_BRIGHTNESS_EN
module neo_channel_scale (
    input  wire logic [7:0] ch,
    input  wire logic [7:0] brightness,
    output logic      [7:0] scaled
);
    logic [8:0]  w_gain;
    logic [15:0] w_prod;

    // Max product 255*256 fits in 16 bits, so brightness=255 is an exact identity.
    assign w_gain = {1'b0, brightness} + 9'd1;
    assign w_prod = 16'(ch) * 16'(w_gain);
    assign scaled = w_prod[15:8];

endmodule
`endif
`default_nettype wire

// File: rtl/neo_pixel_encoder.sv
`default_nettype none
// ============================================================================
// Module   : neo_pixel_encoder
// Brief    : Serialises 24-bit GRB words into the WS2812B single-wire waveform.
//            Optional global brightness scaling under NEO_BRIGHTNESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neo_pixel_encoder
    import neo_pkg::*;
#(
    parameter int T0H_CYCLES   = c_t0h_cycles,
    parameter int T1H_CYCLES   = c_t1h_cycles,
    parameter int BIT_CYCLES   = c_bit_cycles,
    parameter int LATCH_CYCLES = c_latch_cycles
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    neo_pixel_encoder_if.slave pix,
`ifdef NEO_BRIGHTNESS_EN
    input  wire logic [7:0]    brightness,
`endif
    output logic               neo_data,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun
);

    localparam int CYC_W = $clog2(BIT_CYCLES);
    localparam int LAT_W = $clog2(LATCH_CYCLES);

    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] c_cyc_pen  = CYC_W'(BIT_CYCLES - 2);
    localparam logic [CYC_W-1:0] c_t0h      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] c_t1h      = CYC_W'(T1H_CYCLES);
    localparam logic [LAT_W-1:0] c_lat_last = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [LAT_W-1:0] c_lat_pen  = LAT_W'(LATCH_CYCLES - 2);

    neo_state_t       r_state;
    logic [23:0]      r_shreg;
    logic             r_last;
    logic [4:0]       r_bit_cnt;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             r_neo_data;
    logic             r_pix_ready;
    logic             r_busy;
    logic             r_frame_done;

    logic [23:0]      w_load_word;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic             w_accept;

    function automatic logic f_high(input logic [CYC_W-1:0] cyc, input logic msb);
        return cyc < (msb ? c_t1h : c_t0h);
    endfunction

`ifdef NEO_BRIGHTNESS_EN
    logic [23:0] w_raw_word;
    assign w_raw_word = pix.pix_grb;

    for (genvar i = 0; i < 3; i++) begin : g_scale
        neo_channel_scale u_scale (
            .ch         (w_raw_word[8*i +: 8]),
            .brightness (brightness),
            .scaled     (w_load_word[8*i +: 8])
        );
    end
`else
    assign w_load_word = pix.pix_grb;
`endif

    assign w_cyc_nxt = r_cyc_cnt + CYC_W'(1);
    assign w_accept  = r_pix_ready & pix.pix_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_last       <= 1'b0;
            r_bit_cnt    <= '0;
            r_cyc_cnt    <= '0;
            r_lat_cnt    <= '0;
            r_neo_data   <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_neo_data <= 1'b0;
                    if (w_accept) begin
                        r_shreg     <= w_load_word;
                        r_last      <= pix.pix_last;
                        r_bit_cnt   <= 5'd23;
                        r_cyc_cnt   <= '0;
                        r_neo_data  <= f_high('0, w_load_word[23]);
                        r_pix_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end else begin
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                ST_SEND: begin
                    if (r_cyc_cnt != c_cyc_last) begin
                        r_cyc_cnt   <= w_cyc_nxt;
                        r_neo_data  <= f_high(w_cyc_nxt, r_shreg[23]);
                        // Open the ready window only on the final cycle of a non-last pixel.
                        r_pix_ready <= (r_bit_cnt == 5'd0) && (r_cyc_cnt == c_cyc_pen) && !r_last;
                    end else if (r_bit_cnt != 5'd0) begin
                        r_cyc_cnt   <= '0;
                        r_bit_cnt   <= r_bit_cnt - 5'd1;
                        r_shreg     <= {r_shreg[22:0], 1'b0};
                        r_neo_data  <= f_high('0, r_shreg[22]);
                        r_pix_ready <= 1'b0;
                    end else if (r_last) begin
                        r_lat_cnt    <= '0;
                        r_neo_data   <= 1'b0;
                        r_pix_ready  <= 1'b0;
                        r_frame_done <= (c_lat_last == '0);
                        r_state      <= ST_LATCH;
                    end else if (w_accept) begin
                        r_shreg     <= w_load_word;
                        r_last      <= pix.pix_last;
                        r_bit_cnt   <= 5'd23;
                        r_cyc_cnt   <= '0;
                        r_neo_data  <= f_high('0, w_load_word[23]);
                        r_pix_ready <= 1'b0;
                    end else begin
                        r_neo_data  <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_LATCH: begin
                    r_neo_data  <= 1'b0;
                    r_pix_ready <= 1'b0;
                    if (r_lat_cnt != c_lat_last) begin
                        r_lat_cnt    <= r_lat_cnt + LAT_W'(1);
                        r_frame_done <= (r_lat_cnt == c_lat_pen);
                    end else begin
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_neo_data  <= 1'b0;
                    r_pix_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Underrun is only knowable once the final-cycle handshake is seen to be missing.
    assign underrun      = (r_state == ST_SEND) & r_pix_ready & ~pix.pix_valid;
    assign neo_data      = r_neo_data;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign pix.pix_ready = r_pix_ready;

endmodule
`default_nettype wire
